// File: rtl/esfa_program_loader.sv
// ESFA test-program loader: packs a host byte stream into 64-bit test-vector words,
// writes them to the program RAM and verifies the trailing XOR checksum byte.
module esfa_program_loader #(
  parameter int MAX_WORDS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        error_code,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_CKSUM   = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  localparam logic [15:0] MAX_WC = 16'(MAX_WORDS);

  state_t              state_q, state_d;
  logic [2:0]          byte_cnt_q, byte_cnt_d;
  logic [63:0]         shreg_q, shreg_d;
  logic [7:0]          cksum_q, cksum_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [63:0]         mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [1:0]          error_code_q, error_code_d;
  logic [15:0]         word_count_q, word_count_d;
  logic                accept_s;
  logic [63:0]         packed_s;
  logic [ADDR_W-1:0]   wc_ext_s;

  assign accept_s = in_valid & in_ready_q;
  assign packed_s = {in_data, shreg_q[63:8]};
  assign wc_ext_s = ADDR_W'(word_count_q);

  // Next-state and next-output computation for the load sequencer
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    shreg_d      = shreg_q;
    cksum_d      = cksum_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    error_code_d = error_code_q;
    word_count_d = word_count_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d      = S_COLLECT;
          byte_cnt_d   = 3'd0;
          cksum_d      = 8'd0;
          error_code_d = 2'd0;
          word_count_d = 16'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_COLLECT: begin
        if (accept_s) begin
          cksum_d    = cksum_q ^ in_data;
          shreg_d    = packed_s;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd7) begin
            state_d = S_WRITE;
            // The write is launched on entry to WRITE so the word is on the port during WRITE
            if (word_count_q != MAX_WC) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = wc_ext_s << 3;
              mem_wdata_d = packed_s;
            end else begin
              mem_we_d = 1'b0;
            end
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = S_COLLECT;
        end
      end
      S_WRITE: begin
        if (mem_we_q) begin
          word_count_d = word_count_q + 16'd1;
          state_d      = mem_wdata_q[2] ? S_CKSUM : S_COLLECT;
        end else begin
          state_d      = S_ERROR;
          error_code_d = 2'd2;
        end
      end
      S_CKSUM: begin
        if (accept_s) begin
          if (in_data == cksum_q) begin
            state_d = S_DONE;
          end else begin
            state_d      = S_ERROR;
            error_code_d = 2'd1;
          end
        end else begin
          state_d = S_CKSUM;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d = (state_d == S_COLLECT) || (state_d == S_CKSUM);
    busy_d     = (state_d == S_COLLECT) || (state_d == S_WRITE) || (state_d == S_CKSUM);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERROR);
  end

  // State and registered-output flops; reset abandons any load in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 3'd0;
      shreg_q      <= 64'd0;
      cksum_q      <= 8'd0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 64'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      error_code_q <= 2'd0;
      word_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      shreg_q      <= shreg_d;
      cksum_q      <= cksum_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      error_code_q <= error_code_d;
      word_count_q <= word_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign error_code = error_code_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_esfa_program_loader.sv
// Randomized bench for esfa_program_loader: a list-level reference model predicts RAM writes
// and final status; a second instance with MAX_WORDS=2 covers overflow.
module tb_esfa_program_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  int          sel;

  logic        start0, valid0, start1, valid1;
  logic        rdy0, we0, busy0, done0, err0, rdy1, we1, busy1, done1, err1;
  logic [31:0] addr0, addr1;
  logic [63:0] wd0, wd1;
  logic [1:0]  code0, code1;
  logic [15:0] wc0, wc1;

  assign start0 = (sel == 0) && start;
  assign valid0 = (sel == 0) && in_valid;
  assign start1 = (sel == 1) && start;
  assign valid1 = (sel == 1) && in_valid;

  esfa_program_loader #(.MAX_WORDS(256), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start0), .in_valid(valid0), .in_data(in_data),
    .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0), .busy(busy0),
    .done(done0), .error(err0), .error_code(code0), .word_count(wc0));

  esfa_program_loader #(.MAX_WORDS(2), .ADDR_W(32)) dut_small (
    .clk(clk), .reset(reset), .start(start1), .in_valid(valid1), .in_data(in_data),
    .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1), .busy(busy1),
    .done(done1), .error(err1), .error_code(code1), .word_count(wc1));

  logic        rdy_m, we_m, busy_m, done_m, err_m;
  logic [31:0] addr_m;
  logic [63:0] wd_m;
  logic [1:0]  code_m;
  logic [15:0] wc_m;
  assign rdy_m  = (sel == 1) ? rdy1  : rdy0;
  assign we_m   = (sel == 1) ? we1   : we0;
  assign busy_m = (sel == 1) ? busy1 : busy0;
  assign done_m = (sel == 1) ? done1 : done0;
  assign err_m  = (sel == 1) ? err1  : err0;
  assign addr_m = (sel == 1) ? addr1 : addr0;
  assign wd_m   = (sel == 1) ? wd1   : wd0;
  assign code_m = (sel == 1) ? code1 : code0;
  assign wc_m   = (sel == 1) ? wc1   : wc0;

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  typedef struct { logic [31:0] a; logic [63:0] d; } wr_t;
  wr_t  wr_q[$];
  int   cyc = 0;
  int   acc_cnt = 0;
  int   last_acc_cyc = 0;
  int   viol = 0;
  logic prev_we = 1'b0;

  // Count accepted bytes per load and remember the cycle of the latest acceptance
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || (start && !busy_m)) acc_cnt <= 0;
    else if (in_valid && rdy_m) begin
      acc_cnt      <= acc_cnt + 1;
      last_acc_cyc <= cyc;
    end
  end

  // Capture RAM writes; a write must follow an 8th byte by one cycle with in_ready low,
  // and in_ready must return the cycle after
  always @(negedge clk) begin
    if (!reset) begin
      if (we_m) wr_q.push_back('{addr_m, wd_m});
      viol <= viol
            + ((we_m && (rdy_m || (cyc - last_acc_cyc != 1) || (acc_cnt % 8 != 0))) ? 1 : 0)
            + ((prev_we && busy_m && !rdy_m) ? 1 : 0);
    end
    prev_we <= we_m;
  end

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    bit got;
    t = 0;
    got = 1'b0;
    while (!got && t < 100) begin
      @(negedge clk);
      t++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        if (rdy_m) begin
          @(posedge clk);
          got = 1'b1;
        end
      end
    end
    chk("byte_accept", 64'(got), 64'd1);
  endtask

  // Reference model: a list of words yields the expected writes, checksum and final status
  task automatic do_load(input logic [63:0] words[$], input int maxw, input logic [7:0] cks_xor,
                         input bit gaps, input bit mid_start, input string nm);
    logic [7:0] bytes[$];
    logic [7:0] cks;
    int         nw_exp, base, n_got;
    bit         ovf, ok;
    nw_exp = 0;
    ovf    = 1'b0;
    cks    = 8'd0;
    foreach (words[i]) begin
      for (int k = 0; k < 8; k++) bytes.push_back(words[i][8*k +: 8]);
      if (i == maxw) begin
        ovf = 1'b1;
        break;
      end
      nw_exp++;
      for (int k = 0; k < 8; k++) cks = cks ^ words[i][8*k +: 8];
      if (words[i][2]) break;
    end
    if (!ovf) bytes.push_back(cks ^ cks_xor);
    ok   = !ovf && (cks_xor == 8'd0);
    base = wr_q.size();
    pulse_start();
    foreach (bytes[j]) begin
      if (mid_start && j == 3) pulse_start();
      send_byte(bytes[j], gaps);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int t = 0; t < 50 && !(done_m || err_m); t++) @(negedge clk);
    chk({nm, "_finished"}, 64'(done_m || err_m), 64'd1);
    n_got = wr_q.size() - base;
    chk({nm, "_nwrites"}, 64'(n_got), 64'(nw_exp));
    for (int i = 0; i < nw_exp && i < n_got; i++) begin
      chk({nm, "_addr"}, 64'(wr_q[base+i].a), 64'(i * 8));
      chk({nm, "_wdata"}, wr_q[base+i].d, words[i]);
    end
    chk({nm, "_done"}, 64'(done_m), 64'(ok));
    chk({nm, "_error"}, 64'(err_m), 64'(!ok));
    chk({nm, "_code"}, 64'(code_m), ovf ? 64'd2 : ((cks_xor != 8'd0) ? 64'd1 : 64'd0));
    chk({nm, "_wcount"}, 64'(wc_m), 64'(nw_exp));
    if (nw_exp > 0) begin
      chk({nm, "_addr_hold"}, 64'(addr_m), 64'((nw_exp - 1) * 8));
      chk({nm, "_wdata_hold"}, wd_m, words[nw_exp-1]);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_in_ready"}, 64'(rdy_m), 64'd0);
    chk({nm, "_mem_we"}, 64'(we_m), 64'd0);
    chk({nm, "_mem_addr"}, 64'(addr_m), 64'd0);
    chk({nm, "_mem_wdata"}, wd_m, 64'd0);
    chk({nm, "_busy"}, 64'(busy_m), 64'd0);
    chk({nm, "_done"}, 64'(done_m), 64'd0);
    chk({nm, "_error"}, 64'(err_m), 64'd0);
    chk({nm, "_code"}, 64'(code_m), 64'd0);
    chk({nm, "_wcount"}, 64'(wc_m), 64'd0);
  endtask

  function automatic logic [63:0] rnd_word(input bit eop);
    logic [63:0] w;
    w = {$urandom, $urandom};
    w[2] = eop;
    return w;
  endfunction

  initial begin
    logic [63:0] wl[$];
    int          n;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    sel      = 0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    wl = {64'h0007000000000004};
    do_load(wl, 256, 8'h00, 1'b0, 1'b0, "single");

    wl = {rnd_word(1'b0), rnd_word(1'b0), rnd_word(1'b1)};
    do_load(wl, 256, 8'h00, 1'b0, 1'b0, "three");

    wl = {64'h0007000000000004};
    do_load(wl, 256, 8'hFC, 1'b0, 1'b0, "badcks");

    sel = 1;
    wl = {rnd_word(1'b0), rnd_word(1'b0), rnd_word(1'b0)};
    do_load(wl, 2, 8'h00, 1'b0, 1'b0, "overflow");
    sel = 0;

    wl = {rnd_word(1'b0), rnd_word(1'b0), rnd_word(1'b0), rnd_word(1'b1)};
    do_load(wl, 256, 8'h00, 1'b1, 1'b1, "bp_start");

    pulse_start();
    for (int j = 0; j < 5; j++) send_byte(8'($urandom), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("midrst_busy_before", 64'(busy_m), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wl = {64'h0007000000000004};
    do_load(wl, 256, 8'h00, 1'b0, 1'b0, "after_rst");

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 4);
      wl = {};
      for (int i = 0; i < n; i++) wl.push_back(rnd_word(i == n - 1));
      do_load(wl, 256, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    end

    repeat (2) @(negedge clk);
    chk("monitor_violations", 64'(viol), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/esfa_program_loader.md
Name: esfa_program_loader

Overview:
- Writer side of the ESFA test-program memory. Receives a byte stream (valid/ready) from the host link and packs every 8 bytes into one 64-bit test-vector word in the ESFA word layout. Writes each word into the program block RAM at byte addresses 0, 8, 16, …
- Stops after the end-of-program word, then checks one trailing XOR checksum byte. The run controller may start only once done=1 and error=0.

Parameters:
- MAX_WORDS, 256, capacity of the program RAM in 64-bit words.
- ADDR_W, 32, width of the write address (byte address).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a new load from address 0
- in_valid  input  1  byte-stream valid
- in_data  input  8  byte-stream data
- in_ready  output  1  byte accepted when in_valid & in_ready
- mem_we  output  1  RAM write enable, one cycle per word
- mem_addr  output  ADDR_W  RAM byte address (word index × 8)
- mem_wdata  output  64  packed word
- busy  output  1  load in progress
- done  output  1  load finished; level until next start or reset
- error  output  1  load failed; level until next start or reset
- error_code  output  2  0 none, 1 checksum mismatch, 2 overflow
- word_count  output  16  words written so far

Behaviour:
- Reset (async, active-high) values:
  - All outputs 0; state IDLE.
  - Byte counter, word counter, checksum accumulator and shift register are cleared.
  - Reset mid-load abandons the load. The partial RAM contents are not erased.
- States:
  - IDLE: in_ready=0. start → COLLECT; clears done, error, error_code, word_count, byte counter and checksum.
  - COLLECT: in_ready=1, busy=1.
    - Each accepted byte k (k=0..7) goes to bits [8k+7:8k], so the first byte received is the LSB.
    - Each accepted byte is XORed into the checksum.
    - On acceptance of byte 7 → WRITE.
  - WRITE: in_ready=0. Lasts exactly one cycle.
    - Overflow check: if word_count == MAX_WORDS, go to ERROR with code 2, with mem_we=0.
    - Otherwise drive mem_we=1, mem_addr=word_count×8, mem_wdata=packed word, then increment word_count.
    - If word bit[2] (end-of-program) is 1 → CKSUM; else → COLLECT.
  - CKSUM: in_ready=1. On the accepted byte:
    - byte == checksum accumulator (XOR of all program bytes) → DONE.
    - else → ERROR with code 1.
    - The checksum byte is not XORed into the accumulator.
  - DONE: done=1, busy=0, in_ready=0. start → COLLECT (new load).
  - ERROR: error=1, busy=0, in_ready=0. start → COLLECT.
- Latency: the word appears on the RAM port in the cycle after its 8th byte is accepted. Peak throughput is 8 bytes per 9 cycles.
- start while busy (COLLECT/WRITE/CKSUM) is ignored.
- Bytes offered while in_ready=0 are not consumed; the sender holds them.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Arithmetic:
  - mem_addr is word_count zero-extended to ADDR_W, shifted left by 3.
  - word_count never wraps, because overflow is caught before the increment.
- The loader does not interpret other word fields (instruction ID, operands, expected result). They are passed through bit-exact.

Test Plan:
- Single-word load:
  - Stimulus: start, then bytes 04,00,00,00,00,00,07,00, then checksum 03.
  - Required: mem_we=1 once, addr 0, wdata 0x0007000000000004. Then done=1, word_count=1.
- Three-word load:
  - Stimulus: words W0 (bit2=0), W1 (bit2=0), W2 (bit2=1) with in_valid held high continuously, then the correct checksum.
  - Required: writes at addresses 0, 8, 16 in order; in_ready low exactly one cycle after each 8th byte; done=1.
- Bad checksum:
  - Stimulus: same stream as the single-word load, but checksum byte FF.
  - Required: error=1, error_code=1, done=0, word_count=1.
- Overflow:
  - Stimulus: MAX_WORDS=2; send 3 words, none with bit2 set.
  - Required: 2 writes (addresses 0, 8); 3rd word has no write; error_code=2.
- Backpressure and start handling:
  - Stimulus: in_valid toggling randomly; start pulse mid-COLLECT.
  - Required: wdata unaffected by gaps; start ignored.
- Reset mid-load:
  - Stimulus: assert reset after 5 bytes of a word.
  - Required: all outputs 0 immediately without waiting for a clock edge.
  - Then: a subsequent start and a full load behave as in the single-word load.
